// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic matrix multiplier C = A * B with skew, flush and drain.
// Define SYSTOLIC_SAT_OUT_EN to clamp each result lane to the signed DW range.
module systolic_mm_engine #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int DW    = 16,
    parameter int KW    = 8,
    parameter int ACC_W = 2*DW+KW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [KW-1:0]               k_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ROWS*DW-1:0]          in_a,
    input  logic [COLS*DW-1:0]          in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [COLS*ACC_W-1:0]       out_data,
    output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] out_row,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FL = ROWS + COLS - 1;
    localparam int FW = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;
    state_t state, state_nx;

    logic [KW-1:0] k_q, beat;
    logic [FW-1:0] fl_cnt;
    logic [RW-1:0] row;
    logic          done_q, fire, clr, last_row;

    logic [DW-1:0]    a_bus [ROWS][COLS];
    logic [DW-1:0]    b_bus [ROWS][COLS];
    logic [ACC_W-1:0] acc   [ROWS][COLS];

    assign last_row = (row == RW'(ROWS-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        fire      = 1'b0;
        clr       = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clr      = 1'b1;
                    state_nx = (k_len == '0) ? S_DRAIN : S_FEED;
                end
            end
            S_FEED: begin
                in_ready = 1'b1;
                fire     = in_valid;
                if (in_valid && beat == k_q - KW'(1)) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (fl_cnt == FW'(FL-1)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && last_row) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            beat   <= '0;
            fl_cnt <= '0;
            row    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_DRAIN) && out_ready && last_row;
            if (clr) begin
                k_q    <= k_len;
                beat   <= '0;
                fl_cnt <= '0;
                row    <= '0;
            end
            if (fire) beat <= beat + KW'(1);
            if (state == S_FLUSH) fl_cnt <= fl_cnt + FW'(1);
            if (state == S_DRAIN && out_ready)
                row <= last_row ? '0 : row + RW'(1);
        end
    end

    // Bubbles inject zeros so the array can advance every cycle.
    for (genvar i = 0; i < ROWS; i++) begin : g_ska
        logic [DW-1:0] lane;
        assign lane = fire ? in_a[i*DW +: DW] : '0;
        if (i == 0) begin : g_d0
            assign a_bus[i][0] = lane;
        end else begin : g_dl
            logic [DW-1:0] dl [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < i; d++) dl[d] <= '0;
                end else begin
                    dl[0] <= lane;
                    for (int d = 1; d < i; d++) dl[d] <= dl[d-1];
                end
            end
            assign a_bus[i][0] = dl[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_skb
        logic [DW-1:0] lane;
        assign lane = fire ? in_b[j*DW +: DW] : '0;
        if (j == 0) begin : g_d0
            assign b_bus[0][j] = lane;
        end else begin : g_dl
            logic [DW-1:0] dl [j];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < j; d++) dl[d] <= '0;
                end else begin
                    dl[0] <= lane;
                    for (int d = 1; d < j; d++) dl[d] <= dl[d-1];
                end
            end
            assign b_bus[0][j] = dl[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe
            logic [DW-1:0]    a, b;
            logic [2*DW-1:0]  prod;
            logic [ACC_W-1:0] acc_q;
            assign a    = a_bus[i][j];
            assign b    = b_bus[i][j];
            assign prod = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   acc_q <= '0;
                else if (clr) acc_q <= '0;
                else acc_q <= acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
            end
            assign acc[i][j] = acc_q;
            if (j < COLS-1) begin : g_af
                logic [DW-1:0] a_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) a_q <= '0;
                    else        a_q <= a;
                end
                assign a_bus[i][j+1] = a_q;
            end
            if (i < ROWS-1) begin : g_bf
                logic [DW-1:0] b_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) b_q <= '0;
                    else        b_q <= b;
                end
                assign b_bus[i+1][j] = b_q;
            end
        end
    end

`ifdef SYSTOLIC_SAT_OUT_EN
    localparam logic [ACC_W-1:0] SMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    function automatic logic [ACC_W-1:0] fmt(input logic [ACC_W-1:0] v);
        if ($signed(v) > $signed(SMAX)) return SMAX;
        if ($signed(v) < $signed(SMIN)) return SMIN;
        return v;
    endfunction
`else
    function automatic logic [ACC_W-1:0] fmt(input logic [ACC_W-1:0] v);
        return v;
    endfunction
`endif

    always_comb begin
        out_data = '0;
        for (int j = 0; j < COLS; j++)
            out_data[j*ACC_W +: ACC_W] = fmt(acc[row][j]);
    end

    assign out_row  = row;
    assign out_last = out_valid && last_row;
    assign done     = done_q;
endmodule
